spi_responder: RTL

//  Target-side (responder) end of the 4-wire SPI link driven by the chip-select controller.

---
 rtl/spi_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// SPI mode-0 target: oversamples cs_n/sclk/mosi in the clk domain, receives one WORD_W-bit
// word per frame MSB first and returns a preloaded reply word on miso.
module spi_responder #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n_in,
    input  logic              sclk_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic [1:0]        state_num
);

    localparam int             CW       = $clog2(WORD_W) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;

    logic                   w_cs_n;
    logic                   w_sclk;
    logic                   w_mosi;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_start;
    logic                   w_rx_step;
    logic                   w_capture;
    logic                   w_abort;
    logic                   w_shift_out;

    logic [WORD_W-1:0]      r_hold;
    logic                   r_tx_ready;
    logic [WORD_W-1:0]      r_tx_shift;
    logic [WORD_W-1:0]      r_rx_shift;
    logic [CW-1:0]          r_bit_cnt;
    logic [WORD_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    // cs_n synchroniser resets to the deselected level so reset never looks like a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_prev;
    assign w_fall = ~w_sclk & r_sclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Deselect is checked before sclk edges so a coincident edge is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_rx_step   = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_shift_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cs_n) begin
                    w_state_nxt = SHIFT;
                    w_start     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_n) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end else if (w_rise) begin
                    w_rx_step = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = DONE;
                        w_capture   = 1'b1;
                    end
                end else if (w_fall) begin
                    w_shift_out = 1'b1;
                end
            end
            DONE: begin
                if (w_cs_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A load always wins over frame-start consumption so the newest word is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (tx_load) begin
                r_hold     <= tx_data;
                r_tx_ready <= 1'b0;
            end else if (w_start && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
        end else if (w_start) begin
            r_tx_shift <= r_tx_ready ? '0 : r_hold;
        end else if (w_shift_out) begin
            r_tx_shift <= r_tx_shift << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
        end else if (w_start) begin
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
        end else if (w_rx_step) begin
            r_rx_shift <= {r_rx_shift[WORD_W-2:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_capture;
            r_frame_err <= w_abort;
            if (w_capture) r_rx_data <= {r_rx_shift[WORD_W-2:0], w_mosi};
        end
    end

    // Last bit stays on miso through DONE because the final fall never shifts
    assign miso_oe   = (r_state == SHIFT) || (r_state == DONE);
    assign miso_out  = miso_oe & r_tx_shift[WORD_W-1];
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign state_num = r_state;

endmodule
